// File: rtl/pipe_ctrl.sv
// Pipeline handshake controller: per-stage valid/allow_in/load, branch flush
// from the decode stage, and RAW hazard detection against older stages.
// Build option: define PIPE_CTRL_FWD_EN to enable bypass hits; otherwise any
// pending-write match stalls decode.
module pipe_ctrl #(
  parameter int STAGES  = 5,
  parameter int D_STAGE = 1,
  parameter int RA_W    = 5
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_in_valid,
  input  logic [STAGES-1:0]        i_ready_go,
  input  logic                     i_br_taken,
  input  logic [STAGES-1:0]        i_dst_we,
  input  logic [STAGES*RA_W-1:0]   i_dst_addr,
  input  logic [STAGES-1:0]        i_dst_rdy,
  input  logic                     i_src1_use,
  input  logic                     i_src2_use,
  input  logic [RA_W-1:0]          i_src1_addr,
  input  logic [RA_W-1:0]          i_src2_addr,
  output logic [STAGES-1:0]        o_valid,
  output logic [STAGES-1:0]        o_allow_in,
  output logic [STAGES-1:0]        o_load,
  output logic                     o_raw_stall,
  output logic                     o_flush,
  output logic [STAGES-1:0]        o_fwd1_hit,
  output logic [STAGES-1:0]        o_fwd2_hit
);

  localparam logic [STAGES-1:0] ONE = {{(STAGES-1){1'b0}}, 1'b1};

  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] w_m1, w_m2;
  logic              w_raw_stall;
  logic [STAGES-1:0] w_fwd1, w_fwd2;
  logic [STAGES-1:0] w_go;
  logic [STAGES:0]   w_allow;
  logic              w_flush;
  logic [STAGES-1:0] w_load;
  logic [STAGES-1:0] w_valid_d;

  // Youngest in-flight producer per source; WB is excluded because the
  // regfile resolves read-during-write for it.
  always_comb begin
    w_m1 = '0;
    w_m2 = '0;
    // Walk oldest to youngest so the youngest match overwrites the others.
    for (int j = STAGES - 2; j > D_STAGE; j--) begin
      if (r_valid[j] && i_dst_we[j] && (i_dst_addr[j*RA_W +: RA_W] != '0)) begin
        if (i_src1_use && (i_dst_addr[j*RA_W +: RA_W] == i_src1_addr)) w_m1 = ONE << j;
        if (i_src2_use && (i_dst_addr[j*RA_W +: RA_W] == i_src2_addr)) w_m2 = ONE << j;
      end
    end
`ifdef PIPE_CTRL_FWD_EN
    w_raw_stall = (|(w_m1 & ~i_dst_rdy)) | (|(w_m2 & ~i_dst_rdy));
    w_fwd1      = w_m1 & i_dst_rdy;
    w_fwd2      = w_m2 & i_dst_rdy;
`else
    w_raw_stall = (|w_m1) | (|w_m2);
    w_fwd1      = '0;
    w_fwd2      = '0;
`endif
  end

  // Handshake chain, flush, load enables and next-state occupancy.
  always_comb begin
    w_go          = r_valid & i_ready_go;
    w_go[D_STAGE] = r_valid[D_STAGE] & i_ready_go[D_STAGE] & ~w_raw_stall;
    w_allow       = '0;
    w_allow[STAGES] = 1'b1;
    for (int i = STAGES - 1; i >= 0; i--) begin
      w_allow[i] = ~r_valid[i] | (w_go[i] & w_allow[i+1]);
    end
    w_flush   = w_go[D_STAGE] & w_allow[D_STAGE+1] & i_br_taken;
    w_load    = '0;
    w_load[0] = i_in_valid & w_allow[0];
    for (int i = 1; i < STAGES; i++) begin
      // Wrong-path instructions behind the branch are never loaded.
      w_load[i] = w_go[i-1] & w_allow[i] & ~(w_flush & (i <= D_STAGE));
    end
    w_valid_d = r_valid;
    for (int i = 0; i < STAGES; i++) begin
      if (w_load[i]) begin
        w_valid_d[i] = 1'b1;
      end else if (w_go[i] && w_allow[i+1]) begin
        w_valid_d[i] = 1'b0;
      end
      if (w_flush && (i >= 1) && (i <= D_STAGE)) begin
        w_valid_d[i] = 1'b0;
      end
    end
  end

  // Occupancy register; reset discards every stage at once.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid <= '0;
    end else begin
      r_valid <= w_valid_d;
    end
  end

  assign o_valid     = r_valid;
  assign o_allow_in  = w_allow[STAGES-1:0];
  assign o_load      = w_load;
  assign o_raw_stall = w_raw_stall;
  assign o_flush     = w_flush;
  assign o_fwd1_hit  = w_fwd1;
  assign o_fwd2_hit  = w_fwd2;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl (STAGES=5, D_STAGE=1, RA_W=5).
module tb_pipe_ctrl;

  localparam int S  = 5;
  localparam int RW = 5;
`ifdef PIPE_CTRL_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset, in_valid, br_taken, src1_use, src2_use;
  logic [S-1:0]    ready_go, dst_we, dst_rdy;
  logic [S*RW-1:0] dst_addr;
  logic [RW-1:0]   src1_addr, src2_addr;
  logic [S-1:0]    valid, allow_in, load, fwd1_hit, fwd2_hit;
  logic            raw_stall, flush;

  always #5 clk = ~clk;

  pipe_ctrl #(.STAGES(S), .D_STAGE(1), .RA_W(RW)) dut (
    .i_clk(clk), .i_reset(reset), .i_in_valid(in_valid), .i_ready_go(ready_go),
    .i_br_taken(br_taken), .i_dst_we(dst_we), .i_dst_addr(dst_addr), .i_dst_rdy(dst_rdy),
    .i_src1_use(src1_use), .i_src2_use(src2_use), .i_src1_addr(src1_addr),
    .i_src2_addr(src2_addr), .o_valid(valid), .o_allow_in(allow_in), .o_load(load),
    .o_raw_stall(raw_stall), .o_flush(flush), .o_fwd1_hit(fwd1_hit), .o_fwd2_hit(fwd2_hit)
  );

  typedef struct {
    logic rst; logic iv; logic [4:0] rg; logic br;
    logic [4:0] we; logic [24:0] addr; logic [4:0] rdy;
    logic u1; logic [4:0] a1; logic u2; logic [4:0] a2;
    logic [4:0] ev; logic [4:0] ea; logic [4:0] el;
    logic es; logic ef; logic [4:0] e1; logic [4:0] e2;
  } vec_t;

  vec_t vq[$];
  vec_t sq[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [24:0] ad(input int j, input logic [4:0] r);
    ad = 25'(r) << (j * 5);
  endfunction

  function automatic vec_t mk(input logic rst, input logic [4:0] rg, input logic br,
                              input logic [4:0] we, input logic [24:0] addr,
                              input logic [4:0] rdy, input logic u1, input logic [4:0] a1,
                              input logic u2, input logic [4:0] a2,
                              input logic [4:0] ev, input logic [4:0] ea,
                              input logic [4:0] el, input logic es, input logic ef,
                              input logic [4:0] e1, input logic [4:0] e2);
    vec_t v;
    v.rst = rst; v.iv = 1'b1; v.rg = rg; v.br = br; v.we = we; v.addr = addr; v.rdy = rdy;
    v.u1 = u1; v.a1 = a1; v.u2 = u2; v.a2 = a2; v.ev = ev; v.ea = ea; v.el = el;
    v.es = es; v.ef = ef; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  // Row with no register traffic: no stall, no hits expected.
  function automatic vec_t basic(input logic rst, input logic [4:0] rg, input logic br,
                                 input logic [4:0] ev, input logic [4:0] ea,
                                 input logic [4:0] el, input logic ef);
    return mk(rst, rg, br, 5'b0, 25'b0, 5'b0, 1'b0, 5'd0, 1'b0, 5'd0,
              ev, ea, el, 1'b0, ef, 5'b0, 5'b0);
  endfunction

  task automatic chk(input string name, input int idx, input logic [4:0] got,
                     input logic [4:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %b want %b", name, idx, got, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    reset = v.rst; in_valid = v.iv; ready_go = v.rg; br_taken = v.br;
    dst_we = v.we; dst_addr = v.addr; dst_rdy = v.rdy;
    src1_use = v.u1; src1_addr = v.a1; src2_use = v.u2; src2_addr = v.a2;
    #2;
    chk("valid", idx, valid, v.ev);
    chk("allow_in", idx, allow_in, v.ea);
    chk("load", idx, load, v.el);
    chk("raw_stall", idx, {4'b0, raw_stall}, {4'b0, v.es});
    chk("flush", idx, {4'b0, flush}, {4'b0, v.ef});
    chk("fwd1_hit", idx, fwd1_hit, v.e1);
    chk("fwd2_hit", idx, fwd2_hit, v.e2);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Fill from reset, stall stage 3, resume, branch flush, ignored br_taken.
    vq.push_back(basic(1, 5'b11111, 0, 5'b00000, 5'b11111, 5'b00001, 0));
    vq.push_back(basic(0, 5'b11111, 0, 5'b00000, 5'b11111, 5'b00001, 0));
    vq.push_back(basic(0, 5'b11111, 0, 5'b00001, 5'b11111, 5'b00011, 0));
    vq.push_back(basic(0, 5'b11111, 0, 5'b00011, 5'b11111, 5'b00111, 0));
    vq.push_back(basic(0, 5'b11111, 0, 5'b00111, 5'b11111, 5'b01111, 0));
    vq.push_back(basic(0, 5'b11111, 0, 5'b01111, 5'b11111, 5'b11111, 0));
    vq.push_back(basic(0, 5'b10111, 0, 5'b11111, 5'b10000, 5'b00000, 0));
    vq.push_back(basic(0, 5'b10111, 0, 5'b01111, 5'b10000, 5'b00000, 0));
    vq.push_back(basic(0, 5'b11111, 0, 5'b01111, 5'b11111, 5'b11111, 0));
    vq.push_back(basic(0, 5'b11111, 1, 5'b11111, 5'b11111, 5'b11101, 1));
    vq.push_back(basic(0, 5'b11111, 1, 5'b11101, 5'b11111, 5'b11011, 0));
    vq.push_back(basic(0, 5'b11111, 0, 5'b11011, 5'b11111, 5'b10111, 0));
    vq.push_back(basic(0, 5'b11111, 0, 5'b10111, 5'b11111, 5'b01111, 0));
    vq.push_back(basic(0, 5'b11111, 0, 5'b01111, 5'b11111, 5'b11111, 0));
    // Frozen full pipe: hazard-only rows.
    vq.push_back(basic(0, 5'b00000, 1, 5'b11111, 5'b00000, 5'b00000, 0));
    vq.push_back(mk(0, 5'b00000, 0, 5'b00100, ad(2, 5), 5'b00000, 1, 5'd5, 0, 5'd0,
                    5'b11111, 5'b00000, 5'b00000, 1, 0, 5'b0, 5'b0));
    vq.push_back(mk(0, 5'b00000, 0, 5'b00100, ad(2, 5), 5'b00100, 1, 5'd5, 0, 5'd0,
                    5'b11111, 5'b00000, 5'b00000, !FWD, 0, FWD ? 5'b00100 : 5'b0, 5'b0));
    vq.push_back(mk(0, 5'b00000, 0, 5'b01100, ad(2, 7) | ad(3, 7), 5'b01100, 0, 5'd0, 1,
                    5'd7, 5'b11111, 5'b00000, 5'b00000, !FWD, 0, 5'b0,
                    FWD ? 5'b00100 : 5'b0));
    vq.push_back(mk(0, 5'b00000, 0, 5'b01100, ad(2, 7) | ad(3, 7), 5'b01000, 0, 5'd0, 1,
                    5'd7, 5'b11111, 5'b00000, 5'b00000, 1, 0, 5'b0, 5'b0));
    vq.push_back(mk(0, 5'b00000, 0, 5'b00100, 25'b0, 5'b00000, 1, 5'd0, 0, 5'd0,
                    5'b11111, 5'b00000, 5'b00000, 0, 0, 5'b0, 5'b0));
    vq.push_back(mk(0, 5'b00000, 0, 5'b10000, ad(4, 9), 5'b00000, 1, 5'd9, 0, 5'd0,
                    5'b11111, 5'b00000, 5'b00000, 0, 0, 5'b0, 5'b0));
    vq.push_back(mk(0, 5'b00000, 0, 5'b00100, ad(2, 5), 5'b00000, 0, 5'd5, 0, 5'd0,
                    5'b11111, 5'b00000, 5'b00000, 0, 0, 5'b0, 5'b0));
    vq.push_back(mk(0, 5'b00000, 0, 5'b00010, ad(1, 5), 5'b00000, 1, 5'd5, 0, 5'd0,
                    5'b11111, 5'b00000, 5'b00000, 0, 0, 5'b0, 5'b0));
    vq.push_back(mk(0, 5'b00000, 0, 5'b01100, ad(2, 7) | ad(3, 5), 5'b01100, 1, 5'd5, 1,
                    5'd7, 5'b11111, 5'b00000, 5'b00000, !FWD, 0,
                    FWD ? 5'b01000 : 5'b0, FWD ? 5'b00100 : 5'b0));

    // Producer of r5 walks 2 -> 3 -> 4 with result pending; decode stalls
    // until it reaches WB.
    sq.push_back(mk(0, 5'b11111, 0, 5'b00100, ad(2, 5), 5'b00000, 1, 5'd5, 0, 5'd0,
                    5'b11111, 5'b11100, 5'b11000, 1, 0, 5'b0, 5'b0));
    sq.push_back(mk(0, 5'b11111, 0, 5'b01000, ad(3, 5), 5'b00000, 1, 5'd5, 0, 5'd0,
                    5'b11011, 5'b11100, 5'b10000, 1, 0, 5'b0, 5'b0));
    sq.push_back(mk(0, 5'b11111, 0, 5'b10000, ad(4, 5), 5'b00000, 1, 5'd5, 0, 5'd0,
                    5'b10011, 5'b11111, 5'b00111, 0, 0, 5'b0, 5'b0));
    sq.push_back(basic(0, 5'b11111, 0, 5'b00111, 5'b11111, 5'b01111, 0));
    sq.push_back(basic(0, 5'b11111, 0, 5'b01111, 5'b11111, 5'b11111, 0));
    // Reset on a full pipe with a taken branch: everything discarded.
    sq.push_back(basic(1, 5'b11111, 1, 5'b11111, 5'b11111, 5'b11101, 1));
    sq.push_back(basic(0, 5'b11111, 1, 5'b00000, 5'b11111, 5'b00001, 0));

    reset = 1'b1; in_valid = 1'b0; ready_go = '1; br_taken = 1'b0;
    dst_we = '0; dst_addr = '0; dst_rdy = '0;
    src1_use = 1'b0; src2_use = 1'b0; src1_addr = '0; src2_addr = '0;
    @(posedge clk);
    @(posedge clk);
    #1;

    for (int i = 0; i < vq.size(); i++) run_vec(vq[i], i);
    for (int i = 0; i < sq.size(); i++) run_vec(sq[i], 100 + i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
